// File: rtl/uart_rx_os16.sv
// 16x oversampling 8-N-1 UART receiver with mid-bit start validation, stop-bit check
// and a valid/ack holding register with overrun flag. Define UART_RX_PARITY_EN for 8-E-1.
module uart_rx_os16 #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       rxsd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV = CLK_HZ / (16 * BAUD);
  localparam int DW  = $clog2(DIV);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic            rx_meta, rxs;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [3:0]      s_cnt;
  logic [2:0]      b_cnt;
  logic [7:0]      sh;
  logic            accept;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxsd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)   div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick   = (div_cnt == DW'(DIV - 1));
  assign accept = tick && (state == STOP) && (s_cnt == 4'd15) && rxs;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state     <= IDLE;
      s_cnt     <= 4'd0;
      b_cnt     <= 3'd0;
      sh        <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        case (state)
          IDLE: begin
            s_cnt <= 4'd0;
            if (!rxs) state <= START;
          end
          START: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd7) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                s_cnt <= 4'd0;
                b_cnt <= 3'd0;
              end
            end
          end
          DATA: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              sh    <= {rxs, sh[7:1]};
              b_cnt <= b_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (b_cnt == 3'd7) state <= PARITY;
`else
              if (b_cnt == 3'd7) state <= STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              par_bit <= rxs;
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              if (rxs) begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must hold an even count of ones.
                parity_err <= par_bit ^ (^sh);
`endif
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end
          end
          BREAK: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Holding register: a completing byte always wins over a same-cycle acknowledge.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (accept) begin
      rx_data  <= sh;
      rx_valid <= 1'b1;
      overrun  <= rx_valid && !rx_ack;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16 at DIV=6 (100 MHz / 1 Mbaud); honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_os16;

  localparam int BIT = 1000;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       rxsd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, parity_err;

  uart_rx_os16 #(.CLK_HZ(100_000_000), .BAUD(1_000_000)) dut (
    .clk(clk), .reset_p(reset_p), .rxsd(rxsd), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fe;
    logic [7:0] d;
    logic       ovr;
    logic       pe;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push(input logic fe, input logic [7:0] d, input logic ovr, input logic pe);
    exp_t e;
    e.fe = fe; e.d = d; e.ovr = ovr; e.pe = pe;
    sb_q.push_back(e);
  endfunction

  // Monitor: a new byte or a framing error is an output event to be scored.
  always @(negedge clk) begin
    if (!reset_p) begin
      if (frame_err || (rx_valid && (!prev_valid || rx_data != prev_data))) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", {frame_err, rx_valid, rx_data}, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("frame_err", frame_err, e.fe);
          check("parity_err", parity_err, e.pe);
          if (e.fe) begin
            check("valid_on_ferr", rx_valid, 1'b0);
          end else begin
            check("rx_data", rx_data, e.d);
            check("overrun", overrun, e.ovr);
          end
        end
      end
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    rxsd = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rxsd = d[i];
      #(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rxsd = par_ok ? (^d) : ~(^d);
    #(BIT);
`else
    if (par_ok) rxsd = 1'b1;
`endif
    rxsd = stop;
    #(BIT);
    rxsd = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int c = 0;
    while (sb_q.size() != 0 && c < max_cyc) begin
      @(posedge clk);
      c++;
    end
    check("drain_timeout", sb_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #23 reset_p = 1'b0;
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    #(2 * BIT);

    // Clean 0xAF with latency window on rx_valid.
    push(1'b0, 8'hAF, 1'b0, 1'b0);
    fork
      send_frame(8'hAF, 1'b1, 1'b1);
      begin
        #(9000 + EXTRA * 1000) check("valid_not_early", rx_valid, 1'b0);
        #400 check("valid_on_time", rx_valid, 1'b1);
      end
    join
    wait_drain(3000);
    ack_pulse();
    check("ack_clears_valid", rx_valid, 1'b0);
    #(BIT);

    // 300 ns glitch on the idle line.
    rxsd = 1'b0; #300 rxsd = 1'b1;
    #(3 * BIT);
    @(negedge clk);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_overrun", overrun, 1'b0);

    // 0x3C with bad stop held low two bit times, then 0x55.
    push(1'b1, 8'h00, 1'b0, 1'b0);
    push(1'b0, 8'h55, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    rxsd = 1'b0; #(BIT);
    rxsd = 1'b1; #(BIT);
    send_frame(8'h55, 1'b1, 1'b1);
    wait_drain(3000);
    check("valid_55", rx_valid, 1'b1);
    ack_pulse();
    #(BIT);

    // Back-to-back 0x12, 0x34 without acknowledge.
    push(1'b0, 8'h12, 1'b0, 1'b0);
    push(1'b0, 8'h34, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    wait_drain(3000);
    check("ovr_sticky", overrun, 1'b1);
    check("ovr_data", rx_data, 8'h34);
    ack_pulse();
    check("ovr_ack_valid", rx_valid, 1'b0);
    check("ovr_ack_overrun", overrun, 1'b0);
    ack_pulse();
    check("ack_idle_noeffect", rx_valid, 1'b0);
    #(BIT);

    // Reset during bit 4 of 0xF0, then a clean 0xA5.
    fork
      send_frame(8'hF0, 1'b1, 1'b1);
      begin
        #(4 * BIT + BIT / 2 + 3) reset_p = 1'b1;
        #40 reset_p = 1'b0;
      end
    join
    #(2 * BIT);
    @(negedge clk);
    check("abort_valid", rx_valid, 1'b0);
    check("abort_data", rx_data, 8'h00);
    push(1'b0, 8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_drain(3000);
    ack_pulse();
    #(BIT);

`ifdef UART_RX_PARITY_EN
    // 0x07 with wrong parity bit: flagged but still delivered.
    push(1'b0, 8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_drain(3000);
    check("perr_valid", rx_valid, 1'b1);
    ack_pulse();
    #(BIT);
`endif

    check("queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
